// File: rtl/crc_frame_tx_if.sv
// Word-input handshake for crc_frame_tx: the upstream source drives words,
// and the transmitter answers with a combinational ready.
interface crc_frame_tx_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/crc_frame_tx.sv
// Serial frame transmitter: shifts words out MSB-first at the bit_en rate and
// appends the running CRC (init 0, unreflected, no final XOR) after the last word.
module crc_frame_tx #(
  parameter int VERI_BITS = 32,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_en,
  input  logic [VERI_BITS-1:0] veri_poly,
  crc_frame_tx_if.slave        src,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic                 bit_first,
  output logic                 bit_last,
  output logic                 busy
);

  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int CRC_W = (VERI_BITS > 1) ? $clog2(VERI_BITS) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [CRC_W-1:0] CRC_LAST = CRC_W'(VERI_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STALL = 2'd2,
    CRC   = 2'd3
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [DATA_BITS-1:0] buf_reg;
  logic                 last_flag_reg;
  logic [BIT_W-1:0]     bit_idx_reg;
  logic [CRC_W-1:0]     crc_idx_reg;
  logic [VERI_BITS-1:0] crc_reg;
  logic [VERI_BITS-1:0] poly_reg;
  logic                 first_arm_reg;
  logic                 bit_out_reg;
  logic                 bit_valid_reg;
  logic                 bit_first_reg;
  logic                 bit_last_reg;

  logic                 ready;
  logic                 accept;
  logic                 word_end;
  logic                 crc_done;
  logic                 feedback;
  logic [VERI_BITS-1:0] crc_shift;
  logic [VERI_BITS-1:0] crc_data_next;

  // word_end marks the cycle that emits the final bit of the current word
  assign word_end = (state_reg == DATA) && bit_en && (bit_idx_reg == BIT_LAST);
  assign crc_done = (state_reg == CRC) && bit_en && (crc_idx_reg == CRC_LAST);
  assign accept   = src.s_valid && ready;

  assign crc_shift     = {crc_reg[VERI_BITS-2:0], 1'b0};
  assign feedback      = crc_reg[VERI_BITS-1] ^ buf_reg[DATA_BITS-1];
  assign crc_data_next = feedback ? (crc_shift ^ poly_reg) : crc_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = DATA;
      end
      DATA: begin
        if (word_end) begin
          if (last_flag_reg)  state_next = CRC;
          else if (accept)    state_next = DATA;
          else                state_next = STALL;
        end
      end
      STALL: begin
        if (accept) state_next = DATA;
      end
      CRC: begin
        if (crc_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = (state_reg != IDLE);
    case (state_reg)
      IDLE, STALL: ready = 1'b1;
      DATA:        ready = word_end && !last_flag_reg;
      default:     ready = 1'b0;
    endcase
  end

  assign src.s_ready = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_reg       <= '0;
      last_flag_reg <= 1'b0;
      bit_idx_reg   <= '0;
      crc_idx_reg   <= '0;
      crc_reg       <= '0;
      poly_reg      <= '0;
      first_arm_reg <= 1'b0;
      bit_out_reg   <= 1'b0;
      bit_valid_reg <= 1'b0;
      bit_first_reg <= 1'b0;
      bit_last_reg  <= 1'b0;
    end else begin
      bit_valid_reg <= 1'b0;
      bit_first_reg <= 1'b0;
      bit_last_reg  <= 1'b0;

      case (state_reg)
        DATA: begin
          if (bit_en) begin
            bit_out_reg   <= buf_reg[DATA_BITS-1];
            bit_valid_reg <= 1'b1;
            bit_first_reg <= first_arm_reg;
            first_arm_reg <= 1'b0;
            crc_reg       <= crc_data_next;
            buf_reg       <= {buf_reg[DATA_BITS-2:0], 1'b0};
            if (bit_idx_reg == BIT_LAST) begin
              bit_idx_reg <= '0;
              crc_idx_reg <= '0;
            end else begin
              bit_idx_reg <= bit_idx_reg + BIT_W'(1);
            end
          end
        end
        CRC: begin
          if (bit_en) begin
            bit_out_reg   <= crc_reg[VERI_BITS-1];
            bit_valid_reg <= 1'b1;
            bit_last_reg  <= (crc_idx_reg == CRC_LAST);
            crc_reg       <= crc_shift;
            crc_idx_reg   <= crc_idx_reg + CRC_W'(1);
          end
        end
        default: ;
      endcase

      // Placed after the shift so a refill in the word-end cycle wins
      if (accept) begin
        buf_reg       <= src.s_data;
        last_flag_reg <= src.s_last;
        bit_idx_reg   <= '0;
      end

      if (accept && (state_reg == IDLE)) begin
        crc_reg       <= '0;
        poly_reg      <= veri_poly;
        first_arm_reg <= 1'b1;
      end
    end
  end

  assign bit_out   = bit_out_reg;
  assign bit_valid = bit_valid_reg;
  assign bit_first = bit_first_reg;
  assign bit_last  = bit_last_reg;

endmodule
